fetch_pc_unit: RTL

- Upstream companion of the multicycle control FSM.
- Owns the program counter, instruction register, return-address register (RA) and a small return-address stack (RAS).
- Supplies op to the FSM and executes its PC-side strobes: writePC, PCsrc, ImRPC, writeRA, cmpeq, cmpne, backup, restore.
- Sits between instruction memory port 1 and the control unit / register-file datapath.

---
 rtl/fetch_pc_unit_pkg.sv | 38 +++
 rtl/fetch_pc_unit_if.sv | 38 +++
 rtl/fetch_pc_unit_ras_stack.sv | 78 +++++++
 rtl/fetch_pc_unit.sv | 102 ++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC unit and the multicycle control FSM:
// opcode encoding, instruction field positions and the datapath width.
package fetch_pc_unit_pkg;

    localparam int DATA_WIDTH = 16;

    // Instruction field positions
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int ABS_MSB  = 11;
    localparam int REL8_MSB = 7;

    typedef enum logic [3:0] {
        OP_LDA = 4'd0,
        OP_STA = 4'd1,
        OP_ADD = 4'd2,
        OP_JMP = 4'd3,
        OP_CAL = 4'd4,
        OP_BEQ = 4'd5,
        OP_BNE = 4'd6,
        OP_RET = 4'd7,
        OP_LDI = 4'd8,
        OP_SUB = 4'd9,
        OP_MOV = 4'd10,
        OP_CMP = 4'd11,
        OP_PSH = 4'd12,
        OP_POP = 4'd13,
        OP_AND = 4'd14,
        OP_ORR = 4'd15
    } opcode_e;

    // A conditional branch is taken when either enabled condition holds
    function automatic logic branch_taken(input logic cmpeq, input logic cmpne,
                                          input logic eq_flag);
        return (cmpeq & eq_flag) | (cmpne & ~eq_flag);
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bundle between the control FSM / memory side (master) and the fetch/PC
// unit (slave): PC-side strobes in, PC/IR/RA/opcode and stack status out.
interface fetch_pc_unit_if #(
    parameter int WIDTH     = 16,
    parameter int RAS_DEPTH = 8
);
    logic                           MemR1;
    logic [WIDTH-1:0]               instr_in;
    logic                           writePC;
    logic                           PCsrc;
    logic                           ImRPC;
    logic                           writeRA;
    logic                           cmpeq;
    logic                           cmpne;
    logic                           eq_flag;
    logic                           backup;
    logic                           restore;
    logic [WIDTH-1:0]               pc;
    logic [WIDTH-1:0]               ir;
    logic [3:0]                     op;
    logic [WIDTH-1:0]               ra;
    logic [$clog2(RAS_DEPTH):0]     ras_depth;
    logic                           ras_overflow;
    logic                           ras_underflow;

    modport master (
        output MemR1, instr_in, writePC, PCsrc, ImRPC, writeRA,
               cmpeq, cmpne, eq_flag, backup, restore,
        input  pc, ir, op, ra, ras_depth, ras_overflow, ras_underflow
    );

    modport slave (
        input  MemR1, instr_in, writePC, PCsrc, ImRPC, writeRA,
               cmpeq, cmpne, eq_flag, backup, restore,
        output pc, ir, op, ra, ras_depth, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/fetch_pc_unit_ras_stack.sv
// Return-address LIFO. A push while full or a pop while empty leaves the
// stack untouched and raises a sticky flag that only Reset clears.
// Simultaneous push and pop is a no-op.
module fetch_pc_unit_ras_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          push_data,
    output logic [WIDTH-1:0]          top_data,
    output logic [$clog2(DEPTH):0]    depth,
    output logic                      empty,
    output logic                      overflow,
    output logic                      underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic [DW-1:0]    depth_m1;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full;

    assign full      = (depth_q == DW'(DEPTH));
    assign empty     = (depth_q == '0);
    assign depth_m1  = depth_q - 1'b1;
    assign top_data  = stack_q[depth_m1[AW-1:0]];
    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // Next stack contents, occupancy and error flags for this push/pop request
    always_comb begin
        stack_d     = stack_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (push && !pop) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                stack_d[depth_q[AW-1:0]] = push_data;
                depth_d                  = depth_q + 1'b1;
            end
        end else if (pop && !push) begin
            if (empty) begin
                underflow_d = 1'b1;
            end else begin
                depth_d = depth_m1;
            end
        end
    end

    // Stack storage has no reset; occupancy says which entries are valid
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    // Occupancy and sticky flags, cleared synchronously by Reset
    always_ff @(posedge clk) begin
        if (Reset) begin
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/PC unit: owns PC, IR and the return-address register, feeds the
// opcode to the control FSM and executes its PC-side strobes. Saved return
// addresses spill into the RAS so calls can nest beyond one level.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int               WIDTH     = DATA_WIDTH,
    parameter int               RAS_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic          clk,
    input  logic          Reset,
    fetch_pc_unit_if.slave bus
);
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] saved_ra_q, saved_ra_d;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             pop_req;
    logic [WIDTH-1:0] rel12;
    logic [WIDTH-1:0] rel8;
    logic [WIDTH-1:0] call_target;

    assign rel12       = {{(WIDTH-ABS_MSB-1){ir_q[ABS_MSB]}}, ir_q[ABS_MSB:0]};
    assign rel8        = {{(WIDTH-REL8_MSB-1){ir_q[REL8_MSB]}}, ir_q[REL8_MSB:0]};
    assign call_target = {pc_q[WIDTH-1:ABS_MSB+1], ir_q[ABS_MSB:0]};
    assign pop_req     = bus.restore & ~bus.backup;

    // Opcode bypass lets the FSM decode during its fetch cycle
    assign bus.op = bus.MemR1 ? bus.instr_in[OP_MSB:OP_LSB] : ir_q[OP_MSB:OP_LSB];
    assign bus.pc = pc_q;
    assign bus.ir = ir_q;
    assign bus.ra = ra_q;

    fetch_pc_unit_ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .Reset     (Reset),
        .push      (bus.backup),
        .pop       (bus.restore),
        .push_data (saved_ra_q),
        .top_data  (ras_top),
        .depth     (bus.ras_depth),
        .empty     (ras_empty),
        .overflow  (bus.ras_overflow),
        .underflow (bus.ras_underflow)
    );

    // Next PC/IR/RA: return beats call beats relative jump beats increment,
    // and any writePC beats a conditional branch; a pop overrides writeRA
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ra_d       = ra_q;
        saved_ra_d = saved_ra_q;

        if (bus.MemR1) begin
            ir_d = bus.instr_in;
        end

        if (bus.writePC && bus.PCsrc) begin
            pc_d = ra_q;
        end else if (bus.writePC && bus.writeRA) begin
            pc_d = call_target;
        end else if (bus.writePC && bus.ImRPC) begin
            pc_d = pc_q + rel12;
        end else if (bus.writePC) begin
            pc_d = pc_q + 1'b1;
        end else if (branch_taken(bus.cmpeq, bus.cmpne, bus.eq_flag)) begin
            pc_d = pc_q + rel8;
        end

        if (bus.writeRA) begin
            ra_d       = pc_q + 1'b1;
            saved_ra_d = ra_q;
        end

        if (pop_req) begin
            ra_d = ras_empty ? '0 : ras_top;
        end
    end

    // Architectural registers with synchronous reset
    always_ff @(posedge clk) begin
        if (Reset) begin
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            ra_q       <= '0;
            saved_ra_q <= '0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ra_q       <= ra_d;
            saved_ra_q <= saved_ra_d;
        end
    end

endmodule
